arbitro_memoria: RTL

ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

---
 rtl/arbitro_memoria.sv | 131 +++++++++++++
 1 files changed

// File: rtl/arbitro_memoria.sv
// Arbitrates one single-port memory between instruction fetch and data access; data wins until fetch has waited MAX_DM grants.
// Latency: grant to ack >= 2 cycles; if mem_ready never arrives, ack plus bus_err pulse TIMEOUT cycles after grant.
// Backpressure: stall_x is held while x_req is high and x_ack low; the memory throttles through mem_ready.
module arbitro_memoria #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_DM  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          bus_err
);

  localparam int SW = $clog2(MAX_DM + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] dm_streak;
  logic [CW-1:0] tmo_cnt;
  logic          grant_if, grant_dm, done, expire;

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    expire   = 1'b0;
    case (state)
      IDLE: begin
        // The ack cycle is a dead cycle: requesters have not yet dropped req for the finished access.
        if (!(if_ack || dm_ack)) begin
          if (dm_req && (!if_req || dm_streak < SW'(MAX_DM))) begin
            grant_dm = 1'b1;
            state_nx = BUSY_DM;
          end else if (if_req) begin
            grant_if = 1'b1;
            state_nx = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (tmo_cnt >= CW'(TIMEOUT - 1)) begin
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      bus_err   <= 1'b0;
      tmo_cnt   <= '0;
      dm_streak <= '0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;

      if (grant_if || grant_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
        tmo_cnt   <= CW'(1);
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end

      // A timed-out access still completes towards its requester, with zero data.
      if (done || expire) begin
        mem_req <= 1'b0;
        bus_err <= expire;
        if (state == BUSY_IF) begin
          if_ack   <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          dm_ack   <= 1'b1;
          dm_rdata <= done ? mem_rdata : '0;
        end
      end

      if (grant_if)
        dm_streak <= '0;
      else if (grant_dm && if_req && dm_streak < SW'(MAX_DM))
        dm_streak <= dm_streak + SW'(1);
    end
  end

endmodule
